// File: rtl/apb_nb_bridge_if.sv
// APB slave plus native-bus initiator signal bundle for apb_nb_bridge.
// The slave modport is the bridge's view; master is the APB fabric and responder side.
interface apb_nb_bridge_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;
  logic                  nb_cs;
  logic                  nb_we;
  logic                  nb_re;
  logic [ADDR_WIDTH-1:0] nb_addr;
  logic [DATA_WIDTH-1:0] nb_wdata;
  logic [DATA_WIDTH-1:0] nb_rdata;
  logic                  nb_ready;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, nb_rdata, nb_ready,
    output prdata, pready, pslverr, nb_cs, nb_we, nb_re, nb_addr, nb_wdata
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata, nb_rdata, nb_ready,
    input  prdata, pready, pslverr, nb_cs, nb_we, nb_re, nb_addr, nb_wdata
  );
endinterface

// File: rtl/apb_nb_bridge.sv
// APB slave to native-bus initiator: one APB transfer becomes one native request,
// completed on nb_ready or on a bounded timeout with pslverr.
module apb_nb_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  apb_nb_bridge_if.slave        bus
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t                r_state, w_state;
  logic [7:0]            r_cnt, w_cnt;
  logic                  r_write, w_write;
  logic [DATA_WIDTH-1:0] r_prdata, w_prdata;
  logic                  r_pready, w_pready;
  logic                  r_pslverr, w_pslverr;
  logic                  r_cs, w_cs;
  logic                  r_we, w_we;
  logic                  r_re, w_re;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_cs      <= 1'b0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_write   <= w_write;
      r_prdata  <= w_prdata;
      r_pready  <= w_pready;
      r_pslverr <= w_pslverr;
      r_cs      <= w_cs;
      r_we      <= w_we;
      r_re      <= w_re;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
    end
  end

  // Next-state and next-output logic; every output is a register, so inputs
  // only ever reach the pins through one flop stage.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_write   = r_write;
    w_prdata  = r_prdata;
    w_pready  = r_pready;
    w_pslverr = r_pslverr;
    w_cs      = r_cs;
    w_we      = r_we;
    w_re      = r_re;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    case (r_state)
      S_IDLE: begin
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_cs      = 1'b0;
        w_we      = 1'b0;
        w_re      = 1'b0;
        if (bus.psel && !bus.penable) begin
          w_addr  = bus.paddr;
          w_wdata = bus.pwdata;
          w_write = bus.pwrite;
          w_cs    = 1'b1;
          w_we    = bus.pwrite;
          w_re    = !bus.pwrite;
          w_cnt   = '0;
          w_state = S_REQ;
        end
      end
      S_REQ: begin
        w_cnt = r_cnt + 8'd1;
        if (bus.nb_ready) begin
          if (!r_write) w_prdata = bus.nb_rdata;
          w_pready  = 1'b1;
          w_pslverr = 1'b0;
          w_cs      = 1'b0;
          w_we      = 1'b0;
          w_re      = 1'b0;
          w_state   = S_RESP;
        end else if (r_cnt == TO_LAST) begin
          if (!r_write) w_prdata = '0;
          w_pready  = 1'b1;
          w_pslverr = 1'b1;
          w_cs      = 1'b0;
          w_we      = 1'b0;
          w_re      = 1'b0;
          w_state   = S_RESP;
        end
      end
      S_RESP: begin
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_state   = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign bus.prdata   = r_prdata;
  assign bus.pready   = r_pready;
  assign bus.pslverr  = r_pslverr;
  assign bus.nb_cs    = r_cs;
  assign bus.nb_we    = r_we;
  assign bus.nb_re    = r_re;
  assign bus.nb_addr  = r_addr;
  assign bus.nb_wdata = r_wdata;
endmodule

// File: doc/apb_nb_bridge.md
Name: apb_nb_bridge

Overview:
- APB slave to native-bus initiator bridge.
- Accepts one APB transfer at a time and converts it into a single native-bus request (cs/we/re/addr/wdata).
- Drives that request into the team's native-bus memory responder, waits for its ready pulse, then completes the APB access with pready.
- Sits between the APB fabric and the native-bus memory. Adds a bounded timeout so a dead responder cannot hang the APB bus.

Parameters:
DATA_WIDTH, 8, width of pwdata/prdata and native data buses
ADDR_WIDTH, 8, width of paddr and nb_addr
TIMEOUT, 16, max cycles spent in REQ before error completion (legal range 4..255)

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  APB direction, 1 = write
paddr  input  ADDR_WIDTH  APB address
pwdata  input  DATA_WIDTH  APB write data
prdata  output  DATA_WIDTH  APB read data, registered
pready  output  1  APB transfer complete, registered
pslverr  output  1  APB error, valid only with pready
nb_cs  output  1  native chip select
nb_we  output  1  native write request
nb_re  output  1  native read request
nb_addr  output  ADDR_WIDTH  native address
nb_wdata  output  DATA_WIDTH  native write data
nb_rdata  input  DATA_WIDTH  native read data from responder
nb_ready  input  1  native completion pulse from responder

Behaviour:
- Reset is synchronous and active-high.
  - reset=1 at an edge forces state to IDLE and clears the timeout counter.
  - It also drives prdata, pready, pslverr, nb_cs, nb_we, nb_re, nb_addr and nb_wdata to 0.
  - Reset overrides all other inputs, including mid-transfer. The native request is dropped immediately and no pready is issued for the aborted transfer.
- All outputs are registered. No combinational path from any input to any output.
- States:
  - IDLE
    - nb_cs/nb_we/nb_re=0, pready=0.
    - On psel=1 & penable=0 (APB setup): latch paddr→nb_addr, pwdata→nb_wdata, pwrite.
    - Set nb_cs=1, nb_we=pwrite, nb_re=!pwrite; clear counter; go REQ.
    - Any other psel/penable combination: stay IDLE.
  - REQ
    - Hold nb_cs/nb_we/nb_re/nb_addr/nb_wdata stable; counter increments each cycle.
    - If nb_ready=1:
      - On a read, capture nb_rdata→prdata. On a write, prdata is unchanged.
      - pready←1, pslverr←0; drop nb_cs/nb_we/nb_re to 0; go RESP.
    - Else if counter = TIMEOUT-1:
      - pready←1, pslverr←1; prdata←0 on a read; drop native controls; go RESP.
  - RESP
    - pready=1 for exactly one cycle.
    - Next edge: pready←0, pslverr←0; go IDLE.
    - APB inputs are not sampled in RESP, so a new setup cannot be accepted in this cycle.
- nb_ready is ignored outside REQ. The responder's ready is not reset, so X/1 in IDLE or RESP must have no effect.
- Nominal latency against the memory responder (its ready is registered 2 edges after cs):
  - E0 samples setup, giving nb_cs=1.
  - E2: responder raises ready.
  - E3: bridge sees ready, giving pready=1.
  - E4: APB completes, bridge back in IDLE.
  - Result: 1 setup cycle + 4 access cycles (3 wait states).
  - nb_cs is high for exactly 3 cycles. It falls while the responder is in its finish cycle, so the responder returns to idle with cs low.
- Back-to-back APB transfers: the next setup is sampled in IDLE after RESP. Native requests never overlap.
- psel dropped mid-REQ (APB violation): the native transaction still completes, pready still pulses once, and the bridge returns to IDLE.
- Address and data pass through unmodified. Full address range is legal; no wrap logic in the bridge.
- Counter width: 8 bits. Saturation is not reachable given the TIMEOUT range.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with psel=1, penable=0, nb_ready=X -> all outputs 0, state IDLE, no nb_cs pulse during or after reset.
2. Write 0xA5 to 0x3C with the memory responder attached:
   -> nb_cs=nb_we=1, nb_addr=0x3C, nb_wdata=0xA5 for exactly 3 cycles, nb_re=0;
   -> pready=1 for one cycle, 4 cycles after the setup edge; pslverr=0.
3. Read 0x3C after test 2 -> nb_cs=nb_re=1 for 3 cycles; prdata=0xA5 when pready=1, pslverr=0; prdata holds 0xA5 afterwards.
4. Back-to-back: write 0x11→0x00, write 0x22→0xFF, read 0xFF, read 0x00 with no idle gaps -> reads return 0x22 and 0x11; nb_cs is low for at least one cycle between requests.
5. Timeout: nb_ready tied 0, read 0x10 with TIMEOUT=16 -> nb_cs high for 16 cycles, then pready=1, pslverr=1, prdata=0, nb_cs=0; next transfer with the responder restored completes normally with pslverr=0.
6. Reset mid-REQ: assert reset one cycle after nb_cs rises -> next edge nb_cs=0, pready never pulses; a subsequent write 0x5A→0x01 then read of 0x01 returns 0x5A.
